// File: rtl/prefix_add_seq_pkg.sv
// Shared types and sizing helpers for the sequential prefix adder.
// Holds the controller state encoding, the default slice width, and
// functions deriving the slice count and slice-index counter width.
package prefix_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_DEFAULT = 32;

    // Number of slices needed to cover an operand.
    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice-index counter width; at least one bit even for a single slice.
    function automatic int calc_idx_w(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/prefix_add_seq_if.sv
// Operand/result handshake bundle for prefix_add_seq.
// master: operand producer and result consumer; slave: the adder.
// Signals: in_valid/in_ready/a/b/cin/sub in, out_valid/out_ready/sum/cout/ovf out.
interface prefix_add_seq_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/prefix_add_seq_gp_slice.sv
// Purpose: combinational SLICE-bit parallel-prefix group generate/propagate.
// Latency: zero cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: p, g per-bit propagate/generate in; p_pre, g_pre prefix over bits 0..i out.
module gp_slice #(
    parameter int SLICE = 32
) (
    input  logic [SLICE-1:0] p,
    input  logic [SLICE-1:0] g,
    output logic [SLICE-1:0] p_pre,
    output logic [SLICE-1:0] g_pre
);
    localparam int LEVELS = (SLICE <= 1) ? 0 : $clog2(SLICE);

    // Recursive doubling: after level j every bit spans 2^(j+1) bits below it.
    // Bits with fewer than d predecessors keep their propagate (low mask).
    always_comb begin
        logic [SLICE-1:0] gt;
        logic [SLICE-1:0] pt;
        gt = g;
        pt = p;
        for (int j = 0; j < LEVELS; j++) begin
            gt = gt | (pt & (gt << (1 << j)));
            pt = pt & ((pt << (1 << j)) | ~({SLICE{1'b1}} << (1 << j)));
        end
        g_pre = gt;
        p_pre = pt;
    end

endmodule

// File: rtl/prefix_add_seq.sv
// Purpose: WIDTH-bit add/subtract, one SLICE-bit prefix slice per cycle, LSB first.
// Latency: NSLICE RUN cycles after acceptance; out_valid in cycle T+NSLICE+1.
// Backpressure: result held in DONE until out_ready; no new operands accepted meanwhile.
// Ports: clk, rst (async active-high), bus (slave side of prefix_add_seq_if).
module prefix_add_seq
    import prefix_add_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    prefix_add_seq_if.slave bus
);
    // WIDTH must be a whole multiple of SLICE.
    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDXW   = calc_idx_w(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for subtraction
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [IDXW-1:0]  idx;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] p_s;
    logic [SLICE-1:0] g_s;
    logic [SLICE-1:0] p_pre;
    logic [SLICE-1:0] g_pre;
    logic [SLICE:0]   cvec;     // cvec[i] = carry into bit i; cvec[SLICE] = carry out
    logic [SLICE-1:0] sum_s;
    logic             last;

    assign a_s  = a_r[idx*SLICE +: SLICE];
    assign b_s  = b_r[idx*SLICE +: SLICE];
    assign p_s  = a_s ^ b_s;
    assign g_s  = a_s & b_s;
    assign last = (idx == LAST_IDX);

    gp_slice #(.SLICE(SLICE)) u_gp (
        .p     (p_s),
        .g     (g_s),
        .p_pre (p_pre),
        .g_pre (g_pre)
    );

    // Carry-in merge kept outside the prefix unit so it stays carry-agnostic.
    assign cvec  = {g_pre | (p_pre & {SLICE{carry}}), carry};
    assign sum_s = p_s ^ cvec[SLICE-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = RUN;
            RUN:     if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx*SLICE +: SLICE] <= sum_s;
                    carry <= cvec[SLICE];
                    if (last) begin
                        cout_r <= cvec[SLICE];
                        // Signed overflow: carry into MSB differs from carry out of it.
                        ovf_r  <= cvec[SLICE-1] ^ cvec[SLICE];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: doc/prefix_add_seq.md
# prefix_add_seq

Multi-cycle wide-operand adder/subtractor that time-multiplexes a single SLICE-bit parallel-prefix group generate/propagate unit across a WIDTH-bit operation. It processes one slice per cycle, least-significant first, and chains the carry between slices in a register. It sits between a valid/ready operand producer and a valid/ready result consumer. It trades latency for area versus a full-width prefix tree.

## Interface
Parameters:
- WIDTH, 128, operand and result width in bits; must be an integer multiple of SLICE.
- SLICE, 32, bits processed per cycle; the width of the shared prefix unit.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  1: compute a − b, implemented as a + ~b + 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH−1; for subtraction, 0 means borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- NSLICE = WIDTH/SLICE. The slice index counter is $clog2(NSLICE) bits, minimum 1.
- FSM states:
  - IDLE: in_ready=1. Accept when in_valid is high. Capture a, and b inverted if sub=1. Set the carry register to (sub ? 1 : cin). Clear the index. Go to RUN.
  - RUN: in_ready=0. Each cycle process slice k, covering bits [k·SLICE +: SLICE]:
    - Per bit: p = a^b, g = a&b.
    - Prefix G[i] and P[i] over bits 0..i are computed within the slice.
    - Sum bit i = p[i] ^ c_i, where c_0 = carry and c_i = G[i−1] | (P[i−1] & carry).
    - Write the slice into the sum register.
    - Update carry ← G[SLICE−1] | (P[SLICE−1] & carry).
    - On the last slice, also record the carry into the top bit, c_{SLICE−1}.
    - When k = NSLICE−1, go to DONE; otherwise increment k.
  - DONE: out_valid=1. sum, cout and ovf are held stable until out_ready is high, then go to IDLE.
- cout = final carry register value. ovf = c_{SLICE−1} of the last slice XOR cout.
- Acceptance happens only in IDLE. There is no overlap: a new request is accepted no earlier than the cycle after the result handshake.
- in_valid while busy is simply not accepted (in_ready=0). The producer must hold its operands.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, index=0, carry=0.
- All outputs come from registers and state decode. There is no combinational path from in_valid/out_ready to the data outputs.
- Latency: with the acceptance edge at the end of cycle T, RUN occupies cycles T+1..T+NSLICE. out_valid rises in cycle T+NSLICE+1.
- Throughput: at most one operation per NSLICE+2 cycles when out_ready is held high.
- If out_ready is already high when out_valid rises, DONE lasts exactly one cycle.
- Back-pressure: DONE persists indefinitely with all outputs unchanged.
- sum contents are unspecified-but-stable during RUN. They are valid only while out_valid=1.
- rst asserted mid-RUN or mid-DONE:
  - Outputs immediately return to their reset values.
  - The in-flight result is discarded with no out_valid pulse.
  - in_ready=1 after release.
- NSLICE=1 is legal: exactly one RUN cycle.

## Structure
- Package prefix_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - the default SLICE constant;
  - a function computing NSLICE and the index width.
- One sub-module, gp_slice: purely combinational, SLICE-bit. It takes p and g and returns prefix P and G using the team's recursive GP generator.
- The controller instantiates gp_slice once. It muxes the current slice of a and b into it and applies the carry-in merge outside it.

## Test plan
All scenarios use WIDTH=128, SLICE=32.
- a=128'hFFFF…FFFF, b=1, cin=0, sub=0 → sum=0, cout=1, ovf=0. out_valid first appears 5 cycles after acceptance.
- a=128'h7FFF…FFFF, b=1, sub=0 → sum=128'h8000…0000, cout=0, ovf=1. This checks the carry ripples across all four slices.
- a=5, b=7, sub=1 → sum=128'hFFFF…FFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 → sum=2, cout=1.
- Hold out_ready=0 for 10 cycles after out_valid → sum, cout and ovf remain stable, and in_ready=0 throughout. Pulsing in_valid with new operands during this time is ignored.
- Assert rst during the second RUN cycle → out_valid never pulses and in_ready=1 right after release. The next operation, a=1, b=2, gives sum=3.
- Randomised back-to-back stream with out_ready toggling randomly → every result matches a reference model of a + (sub ? ~b + 1 : b + cin), including cout and ovf.
